key_step_counter: RTL and testbench
===================================

Name: key_step_counter

Overview:
Sequential front end for the hex display path. It debounces two active-low pushbuttons (increment/decrement) and accepts a parallel load from switches. It maintains a registered 4-bit value 0..15 that feeds the downstream ≥10 compare / adjusted-digit / 7-segment stage in place of raw SW[3:0]. It also provides a registered ge_ten flag and a one-cycle update pulse.

Parameters:
DEBOUNCE_CYCLES, 500000, stable-level cycles required to accept a key edge (10 ms at 50 MHz); legal range ≥2
WRAP, 1, 1 = modulo-16 wrap on over/underflow; 0 = saturate at 0 / 15
REPEAT_DELAY, 25000000, cycles held before first auto-repeat step (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_inc_n  input  1  raw increment button, active-low, asynchronous to clk
key_dec_n  input  1  raw decrement button, active-low, asynchronous to clk
load  input  1  synchronous load strobe, active-high
load_val  input  4  value loaded when load=1
value  output  4  current count, to downstream SW[3:0] input
ge_ten  output  1  registered (value >= 10)
upd  output  1  one-cycle pulse, high in the first cycle a new accepted event is reflected in value

Behaviour:
- Reset: asynchronous on rst_n low. value=0, ge_ten=0, upd=0, synchronisers=1 (released), both key FSMs in IDLE, all counters 0. Release is synchronous to clk.
- Each key passes through a 2-flop synchroniser, then its own FSM with a log2(DEBOUNCE_CYCLES)-bit counter.
- FSM states:
  - IDLE: sync level high. On sync low → ARM, counter=0.
  - ARM: sync low → counter++; when counter == DEBOUNCE_CYCLES-1 → HELD and issue one step request. Sync high → IDLE, counter=0 (glitch rejected).
  - HELD: sync high → REL, counter=0.
  - REL: sync high → counter++; at DEBOUNCE_CYCLES-1 → IDLE. Sync low → HELD, counter=0 (no new step).
- Latency: pin held low from edge E → value updates at edge E+DEBOUNCE_CYCLES+2. upd is high the following cycle, with value/ge_ten already new. Exactly one step per debounced press.
- Arithmetic: 4-bit.
  - inc: WRAP=1 → 15→0; WRAP=0 → 15 stays 15.
  - dec: WRAP=1 → 0→15; WRAP=0 → 0 stays 0.
  - A saturated step still pulses upd.
- Priority per cycle: load > (inc XOR dec).
  - load=1: value=load_val, upd=1, any step requests that cycle are discarded.
  - inc and dec requests in the same cycle cancel: no change, upd=0.
- ge_ten is registered in the same edge as value, so the two never disagree.
- Reset mid-debounce: all state cleared. A key still held after reset must complete a full ARM interval before stepping.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in HELD, a repeat counter runs. First extra step at REPEAT_DELAY cycles after entering HELD, then one every REPEAT_PERIOD cycles while held. Leaving HELD clears the repeat counter. Repeat steps obey the same wrap/saturate, priority and upd rules.
- Undefined: no repeat logic or counters are synthesised; REPEAT_* are ignored; one step per press.

Test Plan:
- Run with DEBOUNCE_CYCLES=4.
- Reset: assert rst_n=0 mid-count with value=7 → value=0, ge_ten=0, upd=0 immediately, without a clock edge.
- Inc press: hold key_inc_n low 20 cycles → value 0→1 exactly DEBOUNCE_CYCLES+2 edges after first low sample; upd high 1 cycle; no further change while held.
- Glitch: key_dec_n low for 3 cycles, then high → value unchanged, upd never asserted.
- Wrap/saturate:
  - WRAP=1, value=15, inc → 0, ge_ten 1→0.
  - WRAP=0, value=15, inc → 15, upd=1.
  - WRAP=0, value=0, dec → 0.
- Boundary/priority: value=9, inc → 10, ge_ten=1 same cycle. Then load=1, load_val=3 in the same cycle an inc step matures → value=3, step lost. Simultaneous inc+dec maturity → no change, upd=0.
- AUTO_REPEAT_EN (REPEAT_DELAY=10, REPEAT_PERIOD=4): hold inc 30 cycles after debounce → steps at debounce, +10, +14, +18, +22, +26.

Source files
------------

// File: rtl/key_step_counter.sv
// rtl/key_step_counter.sv - debounced inc/dec key counter with parallel load, 0..15 value for the hex display path
// Optional auto-repeat while a key is held: define AUTO_REPEAT_EN.
`timescale 1ns/1ps
module key_step_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       ge_ten,
    output logic       upd
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} key_state_e;

    // Index 0 is the increment key, index 1 the decrement key.
    logic [1:0]    sync1_q, sync2_q;
    key_state_e    state_q [2];
    logic [CW-1:0] cnt_q   [2];
    logic [1:0]    step_req;

    logic [3:0]    value_q, value_d;
    logic          ge_q, ge_d;
    logic          upd_q, upd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {key_dec_n, key_inc_n};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (state_q[k])
                    IDLE: begin
                        if (!sync2_q[k]) begin
                            state_q[k] <= ARM;
                            cnt_q[k]   <= '0;
                        end
                    end
                    ARM: begin
                        if (sync2_q[k]) begin
                            state_q[k] <= IDLE;
                            cnt_q[k]   <= '0;
                        end else if (cnt_q[k] == CNT_MAX) begin
                            state_q[k] <= HELD;
                            cnt_q[k]   <= '0;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (sync2_q[k]) begin
                            state_q[k] <= REL;
                            cnt_q[k]   <= '0;
                        end
                    end
                    REL: begin
                        // A bounce back low during release resumes HELD without a new step.
                        if (!sync2_q[k]) begin
                            state_q[k] <= HELD;
                            cnt_q[k]   <= '0;
                        end else if (cnt_q[k] == CNT_MAX) begin
                            state_q[k] <= IDLE;
                            cnt_q[k]   <= '0;
                        end else begin
                            cnt_q[k] <= cnt_q[k] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q[k] <= IDLE;
                        cnt_q[k]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] REP_MAX    = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [RW-1:0] REP_ONE    = RW'(1);

    logic [RW-1:0] rep_q [2];

    // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) rep_q[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (state_q[k] != HELD) rep_q[k] <= '0;
                else if (rep_q[k] == REP_MAX) rep_q[k] <= REP_RELOAD;
                else rep_q[k] <= rep_q[k] + REP_ONE;
            end
        end
    end
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_unused
    end
`endif

    // Requests are decoded from registered state so the step lands on the ARM->HELD edge.
    always_comb begin
        step_req = '0;
        for (int k = 0; k < 2; k++) begin
            step_req[k] = (state_q[k] == ARM) && !sync2_q[k] && (cnt_q[k] == CNT_MAX);
`ifdef AUTO_REPEAT_EN
            if ((state_q[k] == HELD) && !sync2_q[k] && (rep_q[k] == REP_MAX)) step_req[k] = 1'b1;
`endif
        end
    end

    always_comb begin
        value_d = value_q;
        upd_d   = 1'b0;
        if (load) begin
            value_d = load_val;
            upd_d   = 1'b1;
        end else if (step_req[0] ^ step_req[1]) begin
            upd_d = 1'b1;
            if (step_req[0]) begin
                if (!(value_q == 4'hF && WRAP == 0)) value_d = value_q + 4'd1;
            end else begin
                if (!(value_q == 4'h0 && WRAP == 0)) value_d = value_q - 4'd1;
            end
        end
        ge_d = (value_d >= 4'd10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'd0;
            ge_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ge_q    <= ge_d;
            upd_q   <= upd_d;
        end
    end

    assign value  = value_q;
    assign ge_ten = ge_q;
    assign upd    = upd_q;

endmodule

// File: tb/tb_key_step_counter.sv
// tb/tb_key_step_counter.sv - scoreboard bench for key_step_counter, wrap and saturate instances
`timescale 1ns/1ps
module tb_key_step_counter;

    localparam int D = 4;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD = 8;
`else
    localparam int HOLD = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] inc_n = 2'b11;
    logic [1:0] dec_n = 2'b11;
    logic [1:0] ld = 2'b00;
    logic [3:0] ldv0 = 4'd0, ldv1 = 4'd0;
    logic [3:0] value_w, value_s;
    logic       ge_w, ge_s, upd_w, upd_s;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] v;
        logic       g;
        int         c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] last_v [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_step_counter #(.DEBOUNCE_CYCLES(D), .WRAP(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .key_inc_n(inc_n[0]), .key_dec_n(dec_n[0]),
        .load(ld[0]), .load_val(ldv0), .value(value_w), .ge_ten(ge_w), .upd(upd_w));

    key_step_counter #(.DEBOUNCE_CYCLES(D), .WRAP(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .key_inc_n(inc_n[1]), .key_dec_n(dec_n[1]),
        .load(ld[1]), .load_val(ldv1), .value(value_s), .ge_ten(ge_s), .upd(upd_s));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_upd(input int d, input logic [3:0] v, input logic g, input int c);
        exp_t e;
        e = '{v, g, c};
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic [3:0] v, input logic g, input logic u);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        if (u) begin
            if (sz == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stray_upd dut%0d: upd=1 value=%0d, expected no update (cycle %0d)", d, v, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("value dut%0d", d), int'(v), int'(e.v));
                chk($sformatf("ge_ten dut%0d", d), int'(g), int'(e.g));
                chk($sformatf("upd_cycle dut%0d", d), cyc, e.c);
            end
        end else begin
            chk($sformatf("value_hold dut%0d", d), int'(v), int'(last_v[d]));
        end
        last_v[d] = v;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_v[0] = 4'd0;
            last_v[1] = 4'd0;
        end else begin
            mon(0, value_w, ge_w, upd_w);
            mon(1, value_s, ge_s, upd_s);
        end
    end

    // Debounced step shows up 7 negedges after the key is driven low (DEBOUNCE_CYCLES + 3).
    task automatic press(input int d, input bit pi, input bit pd, input int hold,
                         input bit has_exp, input logic [3:0] v, input logic g);
        @(negedge clk);
        if (pi) inc_n[d] = 1'b0;
        if (pd) dec_n[d] = 1'b0;
        if (has_exp) expect_upd(d, v, g, cyc + 7);
        repeat (hold) @(negedge clk);
        inc_n[d] = 1'b1;
        dec_n[d] = 1'b1;
        repeat (2 * D + 4) @(negedge clk);
    endtask

    task automatic do_load(input int d, input logic [3:0] v, input logic g);
        @(negedge clk);
        ld[d] = 1'b1;
        if (d == 0) ldv0 = v;
        else ldv1 = v;
        expect_upd(d, v, g, cyc + 1);
        @(negedge clk);
        ld[d] = 1'b0;
    endtask

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset value", int'(value_w), 0);
        chk("reset ge_ten", int'(ge_w), 0);
        chk("reset upd", int'(upd_w), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        press(0, 1, 0, HOLD, 1, 4'd1, 1'b0);
        press(0, 0, 1, 3, 0, 4'd0, 1'b0);
        do_load(0, 4'd9, 1'b0);
        press(0, 1, 0, HOLD, 1, 4'd10, 1'b1);
        do_load(0, 4'd15, 1'b1);
        press(0, 1, 0, HOLD, 1, 4'd0, 1'b0);
        press(0, 0, 1, HOLD, 1, 4'd15, 1'b1);

        @(negedge clk);
        inc_n[0] = 1'b0;
        t0 = cyc;
        repeat (6) @(negedge clk);
        ld[0] = 1'b1;
        ldv0 = 4'd3;
        expect_upd(0, 4'd3, 1'b0, t0 + 7);
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (HOLD - 7) @(negedge clk);
        inc_n[0] = 1'b1;
        repeat (2 * D + 4) @(negedge clk);

        press(0, 1, 1, HOLD, 0, 4'd0, 1'b0);

        do_load(1, 4'd15, 1'b1);
        press(1, 1, 0, HOLD, 1, 4'd15, 1'b1);
        do_load(1, 4'd0, 1'b0);
        press(1, 0, 1, HOLD, 1, 4'd0, 1'b0);
        press(1, 1, 0, HOLD, 1, 4'd1, 1'b0);

        do_load(0, 4'd7, 1'b0);
        @(negedge clk);
        inc_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset value", int'(value_w), 0);
        chk("midreset ge_ten", int'(ge_w), 0);
        chk("midreset upd", int'(upd_w), 0);
        chk("midreset value dut1", int'(value_s), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_upd(0, 4'd1, 1'b0, cyc + 7);
        repeat (HOLD) @(negedge clk);
        inc_n[0] = 1'b1;
        repeat (2 * D + 4) @(negedge clk);

`ifdef AUTO_REPEAT_EN
        @(negedge clk);
        inc_n[0] = 1'b0;
        t0 = cyc;
        expect_upd(0, 4'd2, 1'b0, t0 + 7);
        expect_upd(0, 4'd3, 1'b0, t0 + 17);
        expect_upd(0, 4'd4, 1'b0, t0 + 21);
        expect_upd(0, 4'd5, 1'b0, t0 + 25);
        expect_upd(0, 4'd6, 1'b0, t0 + 29);
        expect_upd(0, 4'd7, 1'b0, t0 + 33);
        repeat (32) @(negedge clk);
        inc_n[0] = 1'b1;
        repeat (2 * D + 4) @(negedge clk);
`endif

        repeat (20) @(negedge clk);
        chk("pending dut0", q0.size(), 0);
        chk("pending dut1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
